// File: rtl/timing_pkg.sv
// Shared types and constants for the timing sequencer and its config register bank.
package timing_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_FRAME = 3'd1,
    LAG        = 3'd2,
    RUN        = 3'd3,
    STOP_WAIT  = 3'd4
  } state_t;

  localparam logic [2:0] ADDR_PIX_S  = 3'd0;
  localparam logic [2:0] ADDR_LINE_S = 3'd1;
  localparam logic [2:0] ADDR_PIX_I  = 3'd2;
  localparam logic [2:0] ADDR_LINE_I = 3'd3;
  localparam logic [2:0] ADDR_LAG    = 3'd4;

  localparam int MIN_PIX   = 4;
  localparam int MIN_LINES = 2;

endpackage

// File: rtl/timing_cfg_regs.sv
// Shadow/active config bank: validated writes land in shadow, commit copies to active
// either immediately when idle or in the cycle after a sensor frame pulse.
module timing_cfg_regs
  import timing_pkg::*;
#(
  parameter int bit_cnt_pix_sensor     = 12,
  parameter int bit_cnt_line_sensor    = 12,
  parameter int bit_cnt_pix_interface  = 12,
  parameter int bit_cnt_line_interface = 12,
  parameter int bit_cnt_lag            = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic [2:0]                        wr_addr,
  input  logic [15:0]                       wr_data,
  input  logic                              commit,
  input  logic                              idle,
  input  logic                              sync_frame_sensor,
  output logic [bit_cnt_pix_sensor-1:0]     pix_s,
  output logic [bit_cnt_line_sensor-1:0]    line_s,
  output logic [bit_cnt_pix_interface-1:0]  pix_i,
  output logic [bit_cnt_line_interface-1:0] line_i,
  output logic [bit_cnt_lag-1:0]            lag,
  output logic                              update,
  output logic                              pending,
  output logic                              err
);

  localparam logic [bit_cnt_pix_sensor-1:0]     MIN_PS = bit_cnt_pix_sensor'(MIN_PIX);
  localparam logic [bit_cnt_line_sensor-1:0]    MIN_LS = bit_cnt_line_sensor'(MIN_LINES);
  localparam logic [bit_cnt_pix_interface-1:0]  MIN_PI = bit_cnt_pix_interface'(MIN_PIX);
  localparam logic [bit_cnt_line_interface-1:0] MIN_LI = bit_cnt_line_interface'(MIN_LINES);

  logic [bit_cnt_pix_sensor-1:0]     sh_pix_s;
  logic [bit_cnt_line_sensor-1:0]    sh_line_s;
  logic [bit_cnt_pix_interface-1:0]  sh_pix_i;
  logic [bit_cnt_line_interface-1:0] sh_line_i;
  logic [bit_cnt_lag-1:0]            sh_lag;
  logic                              frame_q;
  logic                              copy;
  logic                              fire;
  logic                              bad;
  logic                              unused_data;

  // Upper data bits beyond each field width are deliberately ignored.
  assign unused_data = ^wr_data;

  assign copy     = pending & (idle | frame_q);
  assign wr_ready = ~copy;
  assign fire     = wr_valid & wr_ready;

  always_comb begin
    bad = 1'b0;
    case (wr_addr)
      ADDR_PIX_S:  bad = wr_data[bit_cnt_pix_sensor-1:0] < MIN_PS;
      ADDR_LINE_S: bad = wr_data[bit_cnt_line_sensor-1:0] < MIN_LS;
      ADDR_PIX_I:  bad = wr_data[bit_cnt_pix_interface-1:0] < MIN_PI;
      ADDR_LINE_I: bad = wr_data[bit_cnt_line_interface-1:0] < MIN_LI;
      ADDR_LAG:    bad = 1'b0;
      default:     bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_pix_s  <= '1;
      sh_line_s <= '1;
      sh_pix_i  <= '1;
      sh_line_i <= '1;
      sh_lag    <= '0;
      pix_s     <= '1;
      line_s    <= '1;
      pix_i     <= '1;
      line_i    <= '1;
      lag       <= '0;
      frame_q   <= 1'b0;
      update    <= 1'b0;
      pending   <= 1'b0;
      err       <= 1'b0;
    end else begin
      frame_q <= sync_frame_sensor;
      update  <= copy;
      if (fire && bad) err <= 1'b1;
      if (fire && !bad) begin
        case (wr_addr)
          ADDR_PIX_S:  sh_pix_s  <= wr_data[bit_cnt_pix_sensor-1:0];
          ADDR_LINE_S: sh_line_s <= wr_data[bit_cnt_line_sensor-1:0];
          ADDR_PIX_I:  sh_pix_i  <= wr_data[bit_cnt_pix_interface-1:0];
          ADDR_LINE_I: sh_line_i <= wr_data[bit_cnt_line_interface-1:0];
          ADDR_LAG:    sh_lag    <= wr_data[bit_cnt_lag-1:0];
          default:     ;
        endcase
      end
      // A commit landing in the copy cycle stays pending for the next boundary.
      if (copy) begin
        pix_s   <= sh_pix_s;
        line_s  <= sh_line_s;
        pix_i   <= sh_pix_i;
        line_i  <= sh_line_i;
        lag     <= sh_lag;
        pending <= commit;
      end else if (commit) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/timing_sequencer.sv
// Sequences sensor then interface timing chains with a line-count lag, stops on a
// sensor frame boundary, and counts interface frames while running.
module timing_sequencer
  import timing_pkg::*;
#(
  parameter int bit_cnt_pix_sensor     = 12,
  parameter int bit_cnt_line_sensor    = 12,
  parameter int bit_cnt_pix_interface  = 12,
  parameter int bit_cnt_line_interface = 12,
  parameter int bit_cnt_lag            = 8
) (
  input  logic                              clk_gen,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              stop,
  input  logic                              cfg_wr_valid,
  output logic                              cfg_wr_ready,
  input  logic [2:0]                        cfg_wr_addr,
  input  logic [15:0]                       cfg_wr_data,
  input  logic                              cfg_commit,
  input  logic                              sync_line_sensor,
  input  logic                              sync_frame_sensor,
  input  logic                              sync_frame_interface,
  output logic                              en_sensor,
  output logic                              en_interface,
  output logic [bit_cnt_pix_sensor-1:0]     pix_per_line_sensor,
  output logic [bit_cnt_line_sensor-1:0]    lines_per_frame_sensor,
  output logic [bit_cnt_pix_interface-1:0]  pix_per_line_interface,
  output logic [bit_cnt_line_interface-1:0] lines_per_frame_interface,
  output logic                              cfg_update,
  output logic                              commit_pending,
  output logic                              cfg_err,
  output logic [15:0]                       frame_cnt,
  output logic                              busy
);

  state_t                 state;
  logic [bit_cnt_lag-1:0] lag;
  logic [bit_cnt_lag-1:0] lag_tgt;
  logic [bit_cnt_lag-1:0] line_cnt;
  logic [bit_cnt_lag-1:0] line_nxt;

  assign busy     = (state != IDLE);
  assign line_nxt = line_cnt + 1'b1;

  timing_cfg_regs #(
    .bit_cnt_pix_sensor    (bit_cnt_pix_sensor),
    .bit_cnt_line_sensor   (bit_cnt_line_sensor),
    .bit_cnt_pix_interface (bit_cnt_pix_interface),
    .bit_cnt_line_interface(bit_cnt_line_interface),
    .bit_cnt_lag           (bit_cnt_lag)
  ) u_cfg (
    .clk              (clk_gen),
    .reset            (reset),
    .wr_valid         (cfg_wr_valid),
    .wr_ready         (cfg_wr_ready),
    .wr_addr          (cfg_wr_addr),
    .wr_data          (cfg_wr_data),
    .commit           (cfg_commit),
    .idle             (state == IDLE),
    .sync_frame_sensor(sync_frame_sensor),
    .pix_s            (pix_per_line_sensor),
    .line_s           (lines_per_frame_sensor),
    .pix_i            (pix_per_line_interface),
    .line_i           (lines_per_frame_interface),
    .lag              (lag),
    .update           (cfg_update),
    .pending          (commit_pending),
    .err              (cfg_err)
  );

  always_ff @(posedge clk_gen) begin
    if (reset) begin
      state        <= IDLE;
      en_sensor    <= 1'b0;
      en_interface <= 1'b0;
      frame_cnt    <= '0;
      line_cnt     <= '0;
      lag_tgt      <= '0;
    end else begin
      if (state == RUN && sync_frame_interface) frame_cnt <= frame_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state     <= WAIT_FRAME;
            en_sensor <= 1'b1;
            frame_cnt <= '0;
          end
        end
        WAIT_FRAME: begin
          if (stop) begin
            state <= STOP_WAIT;
          end else if (sync_frame_sensor) begin
            line_cnt <= '0;
            lag_tgt  <= lag;
            state    <= (lag == '0) ? RUN : LAG;
          end
        end
        LAG: begin
          // A line pulse coincident with a frame pulse is line 0, not a new line.
          if (stop) begin
            state <= STOP_WAIT;
          end else if (sync_line_sensor && !sync_frame_sensor) begin
            line_cnt <= line_nxt;
            if (line_nxt == lag_tgt) state <= RUN;
          end
        end
        RUN: begin
          en_interface <= 1'b1;
          if (stop) state <= STOP_WAIT;
        end
        STOP_WAIT: begin
          if (sync_frame_sensor) begin
            en_sensor    <= 1'b0;
            en_interface <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timing_sequencer.sv
// Directed bench for timing_sequencer: config commit, lag sequencing, stop, errors, reset.
module tb_timing_sequencer;

  logic        clk_gen = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, stop = 1'b0;
  logic        cfg_wr_valid = 1'b0;
  logic        cfg_wr_ready;
  logic [2:0]  cfg_wr_addr = 3'd0;
  logic [15:0] cfg_wr_data = 16'd0;
  logic        cfg_commit = 1'b0;
  logic        sync_line_sensor = 1'b0, sync_frame_sensor = 1'b0, sync_frame_interface = 1'b0;
  logic        en_sensor, en_interface;
  logic [11:0] pix_per_line_sensor, lines_per_frame_sensor;
  logic [11:0] pix_per_line_interface, lines_per_frame_interface;
  logic        cfg_update, commit_pending, cfg_err, busy;
  logic [15:0] frame_cnt;

  int errors = 0;
  int checks = 0;

  timing_sequencer dut (
    .clk_gen(clk_gen), .reset(reset), .start(start), .stop(stop),
    .cfg_wr_valid(cfg_wr_valid), .cfg_wr_ready(cfg_wr_ready),
    .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data), .cfg_commit(cfg_commit),
    .sync_line_sensor(sync_line_sensor), .sync_frame_sensor(sync_frame_sensor),
    .sync_frame_interface(sync_frame_interface),
    .en_sensor(en_sensor), .en_interface(en_interface),
    .pix_per_line_sensor(pix_per_line_sensor), .lines_per_frame_sensor(lines_per_frame_sensor),
    .pix_per_line_interface(pix_per_line_interface),
    .lines_per_frame_interface(lines_per_frame_interface),
    .cfg_update(cfg_update), .commit_pending(commit_pending), .cfg_err(cfg_err),
    .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 clk_gen = ~clk_gen;

  task automatic step();
    @(posedge clk_gen);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    cfg_wr_valid = 1'b1; cfg_wr_addr = a; cfg_wr_data = d;
    step();
    cfg_wr_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    cfg_commit = 1'b1; step(); cfg_commit = 1'b0;
  endtask

  initial begin
    // Reset state
    step(); step();
    reset = 1'b0;
    chk("rst_en_s", en_sensor, 0);
    chk("rst_en_i", en_interface, 0);
    chk("rst_upd", cfg_update, 0);
    chk("rst_pend", commit_pending, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_fcnt", frame_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pix_s", pix_per_line_sensor, 4095);
    chk("rst_line_i", lines_per_frame_interface, 4095);
    chk("rst_ready", cfg_wr_ready, 1);

    // Idle commit: copy in the cycle after the commit, update visible 2 cycles on
    wr(3'd0, 16'd800);
    wr(3'd1, 16'd600);
    pulse_commit();
    chk("idle_pend", commit_pending, 1);
    chk("idle_ready_copy", cfg_wr_ready, 0);
    chk("idle_upd_early", cfg_update, 0);
    chk("idle_pix_early", pix_per_line_sensor, 4095);
    step();
    chk("idle_upd", cfg_update, 1);
    chk("idle_pix_s", pix_per_line_sensor, 800);
    chk("idle_line_s", lines_per_frame_sensor, 600);
    chk("idle_pend_clr", commit_pending, 0);
    step();
    chk("idle_upd_1cyc", cfg_update, 0);

    // Lag 3 sequencing
    wr(3'd4, 16'd3);
    pulse_commit();
    step();
    step();
    start = 1'b1; step(); start = 1'b0;
    chk("start_en_s", en_sensor, 1);
    chk("start_busy", busy, 1);
    chk("start_en_i", en_interface, 0);
    sync_frame_sensor = 1'b1; step(); sync_frame_sensor = 1'b0;
    for (int k = 0; k < 3; k++) begin
      repeat (9) step();
      sync_line_sensor = 1'b1; step(); sync_line_sensor = 1'b0;
      chk("lag_en_i_low", en_interface, 0);
    end
    step();
    chk("lag_en_i_high", en_interface, 1);
    sync_frame_interface = 1'b1; step(); sync_frame_interface = 1'b0;
    step();
    sync_frame_interface = 1'b1; step(); sync_frame_interface = 1'b0;
    chk("run_fcnt2", frame_cnt, 2);

    // Commit while running waits for a sensor frame boundary
    wr(3'd2, 16'd640);
    pulse_commit();
    chk("run_pend", commit_pending, 1);
    chk("run_pix_i_hold", pix_per_line_interface, 4095);
    repeat (3) step();
    chk("run_pend_hold", commit_pending, 1);
    chk("run_pix_i_hold2", pix_per_line_interface, 4095);
    chk("run_upd_low", cfg_update, 0);
    sync_frame_sensor = 1'b1; step(); sync_frame_sensor = 1'b0;
    chk("run_ready_copy", cfg_wr_ready, 0);
    chk("run_upd_early", cfg_update, 0);
    step();
    chk("run_upd", cfg_update, 1);
    chk("run_pix_i", pix_per_line_interface, 640);
    chk("run_pend_clr", commit_pending, 0);

    // Stop in RUN: enables hold until next sensor frame
    stop = 1'b1; step(); stop = 1'b0;
    chk("stop_en_s_hold", en_sensor, 1);
    chk("stop_en_i_hold", en_interface, 1);
    repeat (3) step();
    chk("stop_busy_hold", busy, 1);
    chk("stop_en_i_hold2", en_interface, 1);
    sync_frame_sensor = 1'b1; step(); sync_frame_sensor = 1'b0;
    chk("stop_en_s", en_sensor, 0);
    chk("stop_en_i", en_interface, 0);
    chk("stop_busy", busy, 0);
    chk("stop_fcnt_held", frame_cnt, 2);
    sync_frame_interface = 1'b1; step(); sync_frame_interface = 1'b0;
    chk("idle_fcnt_nocount", frame_cnt, 2);

    // Bad writes
    wr(3'd6, 16'd123);
    chk("err_addr", cfg_err, 1);
    wr(3'd0, 16'd2);
    pulse_commit();
    step();
    chk("err_commit_upd", cfg_update, 1);
    chk("err_pix_s_kept", pix_per_line_sensor, 800);
    chk("err_sticky", cfg_err, 1);
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk("startstop_busy", busy, 0);
    chk("startstop_en_s", en_sensor, 0);

    // Reset during LAG
    start = 1'b1; step(); start = 1'b0;
    chk("restart_fcnt_clr", frame_cnt, 0);
    sync_frame_sensor = 1'b1; step(); sync_frame_sensor = 1'b0;
    sync_line_sensor = 1'b1; step(); sync_line_sensor = 1'b0;
    chk("lag_busy", busy, 1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("mid_rst_en_s", en_sensor, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pix_s", pix_per_line_sensor, 4095);
    chk("mid_rst_err", cfg_err, 0);

    // Lag 0 after reset: RUN straight from the frame pulse
    start = 1'b1; step(); start = 1'b0;
    sync_frame_sensor = 1'b1; step(); sync_frame_sensor = 1'b0;
    chk("lag0_en_i_low", en_interface, 0);
    step();
    chk("lag0_en_i", en_interface, 1);
    stop = 1'b1; step(); stop = 1'b0;
    sync_frame_sensor = 1'b1; step(); sync_frame_sensor = 1'b0;
    chk("lag0_stopped", busy, 0);

    // Lag 1: coincident frame+line pulses are line 0, not counted
    wr(3'd4, 16'd1);
    pulse_commit();
    step();
    start = 1'b1; step(); start = 1'b0;
    sync_frame_sensor = 1'b1; sync_line_sensor = 1'b1; step();
    sync_frame_sensor = 1'b0; sync_line_sensor = 1'b0;
    step(); step();
    chk("coinc_wait_en_i", en_interface, 0);
    sync_frame_sensor = 1'b1; sync_line_sensor = 1'b1; step();
    sync_frame_sensor = 1'b0; sync_line_sensor = 1'b0;
    step(); step();
    chk("coinc_lag_en_i", en_interface, 0);
    sync_line_sensor = 1'b1; step(); sync_line_sensor = 1'b0;
    step();
    chk("lag1_en_i", en_interface, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
